// File: rtl/spi_ram_if.sv
// spi_ram_if: word-level link between the SPI slave and spi_ram.
//   rx_data  [9:8] command, [7:0] address/data payload
//   rx_valid one command per cycle while high
//   tx_data  read byte returned to the SPI slave
//   tx_valid one-cycle pulse marking a fresh tx_data
//   seq_err  sticky read-before-address flag
// The master modport is the SPI slave side; the slave modport is the RAM side.
interface spi_ram_if;
    logic [9:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       seq_err;

    modport master (
        output rx_data, rx_valid,
        input  tx_data, tx_valid, seq_err
    );

    modport slave (
        input  rx_data, rx_valid,
        output tx_data, tx_valid, seq_err
    );
endinterface

// File: rtl/spi_ram.sv
// spi_ram: single-port byte RAM driven by 10-bit command words from an SPI slave.
//   CLK  rising-edge clock shared with the SPI slave
//   rst  synchronous, active-high reset (memory contents are kept)
//   bus  spi_ram_if.slave: rx_data/rx_valid in, tx_data/tx_valid/seq_err out
// Commands (rx_data[9:8]): 00 set write pointer, 01 write byte, 10 set read
// pointer, 11 read byte (payload ignored). With AUTO_INC=1 the pointer used by
// a data command post-increments, wrapping modulo MEM_DEPTH.
module spi_ram #(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_SIZE = 8,
    parameter int AUTO_INC  = 0
) (
    input  logic       CLK,
    input  logic       rst,
    spi_ram_if.slave   bus
);

    typedef enum logic [1:0] {
        CMD_WR_ADDR = 2'b00,
        CMD_WR_DATA = 2'b01,
        CMD_RD_ADDR = 2'b10,
        CMD_RD_DATA = 2'b11
    } cmd_e;

    logic [7:0]           mem [MEM_DEPTH];
    logic [ADDR_SIZE-1:0] wr_addr;
    logic [ADDR_SIZE-1:0] rd_addr;
    logic                 rd_addr_ok;

    logic wr_addr_en, wr_data_en, rd_addr_en, rd_data_en;

    // Decode is gated by rx_valid so an undriven rx_data never reaches state.
    always_comb begin
        wr_addr_en = 1'b0;
        wr_data_en = 1'b0;
        rd_addr_en = 1'b0;
        rd_data_en = 1'b0;
        if (bus.rx_valid) begin
            case (bus.rx_data[9:8])
                CMD_WR_ADDR: wr_addr_en = 1'b1;
                CMD_WR_DATA: wr_data_en = 1'b1;
                CMD_RD_ADDR: rd_addr_en = 1'b1;
                default:     rd_data_en = 1'b1;
            endcase
        end
    end

    // Storage has no reset so its contents survive rst.
    always_ff @(posedge CLK) begin
        if (!rst && wr_data_en)
            mem[wr_addr] <= bus.rx_data[7:0];
    end

    // Pointer width equals log2(MEM_DEPTH), so +1 wraps on its own.
    always_ff @(posedge CLK) begin
        if (rst) begin
            wr_addr      <= '0;
            rd_addr      <= '0;
            rd_addr_ok   <= 1'b0;
            bus.tx_data  <= 8'h00;
            bus.tx_valid <= 1'b0;
            bus.seq_err  <= 1'b0;
        end else begin
            bus.tx_valid <= rd_data_en;
            if (wr_addr_en)
                wr_addr <= bus.rx_data[ADDR_SIZE-1:0];
            if (wr_data_en && AUTO_INC != 0)
                wr_addr <= wr_addr + ADDR_SIZE'(1);
            if (rd_addr_en) begin
                rd_addr    <= bus.rx_data[ADDR_SIZE-1:0];
                rd_addr_ok <= 1'b1;
            end
            if (rd_data_en) begin
                // A read without a prior read-address still completes so the
                // SPI slave never stalls; it only raises the sticky flag.
                bus.tx_data <= mem[rd_addr];
                if (!rd_addr_ok)
                    bus.seq_err <= 1'b1;
                if (AUTO_INC != 0)
                    rd_addr <= rd_addr + ADDR_SIZE'(1);
            end
        end
    end

endmodule
